// File: rtl/sccb_init_seq_pkg.sv
// Shared encodings for the SCCB init sequencer: bus commands, response
// codes, table marker values and the sequencer state type.
package sccb_init_seq_pkg;

  // Bus command encodings (host and bridge ports share them)
  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  // Bus response: data valid / accepted
  localparam logic [1:0] RESP_DVA = 2'b01;

  // Table markers: whole-entry end marker and the register value that
  // turns an entry into a delay request
  localparam logic [15:0] MARK_END   = 16'hFFFF;
  localparam logic [7:0]  MARK_DELAY = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_ACC,
    ST_WAIT_CMPL,
    ST_DELAY,
    ST_DONE
  } state_e;

  // Delay length in sccb_clk cycles for a delay entry; kept at 24 bits so
  // val * unit cannot overflow for 8-bit val and 16-bit unit.
  function automatic logic [23:0] delay_cycles(input logic [7:0] val,
                                                input logic [15:0] unit);
    return {16'd0, val} * {8'd0, unit};
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Init table storage: 256 x 16 entries {reg, val}, one-cycle registered
// read. A write port lets the level above load the table contents.
module sccb_init_rom (
  input  logic        sccb_clk,
  input  logic [7:0]  addr_i,
  output logic [15:0] data_o,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_addr_i,
  input  logic [15:0] wr_data_i
);

  logic [15:0] mem_q [256];

  // Table load and registered read
  always_ff @(posedge sccb_clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    data_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sccb_init_seq.sv
// SCCB init sequencer: walks a {reg, val} table and issues each entry as
// a write to the SCCB bridge, with delay entries and an end marker. When
// not running, the host port passes straight through to the bridge.
module sccb_init_seq
  import sccb_init_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ID     = 7'h21,
  parameter logic [15:0] DELAY_UNIT = 16'd50000,
  parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic        sccb_clk,
  input  logic        sccb_reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [2:0]  h_mcmd,
  input  logic [14:0] h_maddr,
  input  logic [7:0]  h_mdata,
  output logic        h_scmdaccept,
  output logic [1:0]  h_sresp,
  output logic [7:0]  h_sdata,
  output logic [2:0]  m_mcmd,
  output logic [14:0] m_maddr,
  output logic [7:0]  m_mdata,
  input  logic        m_scmdaccept,
  input  logic [1:0]  m_sresp,
  input  logic [7:0]  m_sdata,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data
);

  state_e      state_q;
  logic        busy_q, done_q, error_q, pend_q;
  logic [7:0]  index_q;
  logic [23:0] dly_q;
  logic [19:0] tmo_q;
  logic [2:0]  m_mcmd_q;
  logic [14:0] m_maddr_q;
  logic [7:0]  m_mdata_q;

  logic        host_own;
  logic        start_ok;
  logic        last_entry;
  logic        tmo_hit;
  logic [7:0]  index_d;
  logic [19:0] tmo_d;
  logic [23:0] dly_d;

  assign host_own   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // Only hand the bridge to the sequencer when it is idle and the host
  // is not in the middle of presenting a command.
  assign start_ok   = (start || pend_q) && m_scmdaccept && (h_mcmd == CMD_IDLE);
  assign last_entry = (index_q == 8'hFF);
  assign tmo_hit    = (tmo_q >= TIMEOUT - 20'd1);
  assign index_d    = index_q + 8'd1;
  assign tmo_d      = tmo_q + 20'd1;
  assign dly_d      = dly_q - 24'd1;

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      pend_q    <= 1'b0;
      index_q   <= 8'd0;
      dly_q     <= 24'd0;
      tmo_q     <= 20'd0;
      m_mcmd_q  <= CMD_IDLE;
      m_maddr_q <= 15'd0;
      m_mdata_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            pend_q   <= 1'b0;
            index_q  <= 8'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
            m_mcmd_q <= CMD_IDLE;
            state_q  <= ST_FETCH;
          end else if (start) begin
            pend_q <= 1'b1;
          end
        end
        // rom_addr follows index_q; the ROM output is valid next cycle
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (rom_data == MARK_END) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (rom_data[15:8] == MARK_DELAY) begin
            dly_q   <= delay_cycles(rom_data[7:0], DELAY_UNIT);
            state_q <= ST_DELAY;
          end else begin
            m_mcmd_q  <= CMD_WR;
            m_maddr_q <= {DEV_ID, rom_data[15:8]};
            m_mdata_q <= rom_data[7:0];
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_q   <= 20'd0;
          state_q <= ST_WAIT_ACC;
        end
        // Bridge signals acceptance by dropping m_scmdaccept
        ST_WAIT_ACC: begin
          if (!m_scmdaccept) begin
            m_mcmd_q <= CMD_IDLE;
            tmo_q    <= 20'd0;
            state_q  <= ST_WAIT_CMPL;
          end else if (tmo_hit) begin
            m_mcmd_q <= CMD_IDLE;
            error_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        // Bridge returning to accept-ready means the transfer finished
        ST_WAIT_CMPL: begin
          if (m_scmdaccept) begin
            if (last_entry) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              index_q <= index_d;
              state_q <= ST_FETCH;
            end
          end else if (tmo_hit) begin
            m_mcmd_q <= CMD_IDLE;
            error_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_DELAY: begin
          if (dly_q == 24'd0) begin
            if (last_entry) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              index_q <= index_d;
              state_q <= ST_FETCH;
            end
          end else begin
            dly_q <= dly_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign rom_addr = index_q;

  // Bridge side: host passthrough when idle, sequencer registers otherwise
  assign m_mcmd  = host_own ? h_mcmd  : m_mcmd_q;
  assign m_maddr = host_own ? h_maddr : m_maddr_q;
  assign m_mdata = host_own ? h_mdata : m_mdata_q;

  // Host side: bridge responses are hidden while the sequencer owns it
  assign h_scmdaccept = host_own ? m_scmdaccept : 1'b0;
  assign h_sresp      = host_own ? m_sresp      : 2'b00;
  assign h_sdata      = host_own ? m_sdata      : 8'h00;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq with a behavioural bridge model,
// a list-based reference model of the table walk, and the init ROM.
module tb_sccb_init_seq;
  import sccb_init_seq_pkg::*;

  localparam logic [6:0] DEV = 7'h21;

  logic        sccb_clk = 1'b0;
  logic        sccb_reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [2:0]  h_mcmd = 3'b000;
  logic [14:0] h_maddr = 15'd0;
  logic [7:0]  h_mdata = 8'd0;
  logic        h_scmdaccept;
  logic [1:0]  h_sresp;
  logic [7:0]  h_sdata;
  logic [2:0]  m_mcmd;
  logic [14:0] m_maddr;
  logic [7:0]  m_mdata;
  logic        m_scmdaccept;
  logic [1:0]  m_sresp;
  logic [7:0]  m_sdata;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        rom_we = 1'b0;
  logic [7:0]  rom_wa = 8'd0;
  logic [15:0] rom_wd = 16'd0;

  always #5 sccb_clk = ~sccb_clk;

  sccb_init_seq #(.DEV_ID(DEV), .DELAY_UNIT(16'd10), .TIMEOUT(20'd100)) dut (
    .sccb_clk(sccb_clk), .sccb_reset_n(sccb_reset_n), .start(start),
    .busy(busy), .done(done), .error(error),
    .h_mcmd(h_mcmd), .h_maddr(h_maddr), .h_mdata(h_mdata),
    .h_scmdaccept(h_scmdaccept), .h_sresp(h_sresp), .h_sdata(h_sdata),
    .m_mcmd(m_mcmd), .m_maddr(m_maddr), .m_mdata(m_mdata),
    .m_scmdaccept(m_scmdaccept), .m_sresp(m_sresp), .m_sdata(m_sdata),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  sccb_init_rom rom (
    .sccb_clk(sccb_clk), .addr_i(rom_addr), .data_o(rom_data),
    .wr_en_i(rom_we), .wr_addr_i(rom_wa), .wr_data_i(rom_wd)
  );

  // Bridge model: accepts a write acc_lat cycles after it appears, then
  // stays busy cmpl_lat cycles. Response lines carry random noise.
  bit   bm_en = 1'b0, bm_stuck = 1'b0;
  int   acc_lat = 2, cmpl_lat = 40;
  logic bm_acc, bm_busy;
  int   bm_cnt;
  logic [1:0] noise_resp;
  logic [7:0] noise_sdata;
  logic       man_acc = 1'b1;
  logic [1:0] man_resp = 2'b00;
  logic [7:0] man_sdata = 8'h00;
  logic [14:0] wa_log[$];
  logic [7:0]  wd_log[$];

  always @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      bm_acc <= 1'b1; bm_busy <= 1'b0; bm_cnt <= 0;
      noise_resp <= 2'b00; noise_sdata <= 8'h00;
    end else begin
      noise_resp  <= 2'($urandom);
      noise_sdata <= 8'($urandom);
      if (!bm_en) begin
        bm_acc <= 1'b1; bm_busy <= 1'b0; bm_cnt <= 0;
      end else if (!bm_busy) begin
        if (m_mcmd == CMD_WR && !bm_stuck) begin
          if (bm_cnt >= acc_lat - 1) begin
            bm_acc <= 1'b0; bm_busy <= 1'b1; bm_cnt <= 0;
            wa_log.push_back(m_maddr);
            wd_log.push_back(m_mdata);
          end else bm_cnt <= bm_cnt + 1;
        end else bm_cnt <= 0;
      end else if (bm_cnt >= cmpl_lat - 1) begin
        bm_acc <= 1'b1; bm_busy <= 1'b0; bm_cnt <= 0;
      end else bm_cnt <= bm_cnt + 1;
    end
  end

  assign m_scmdaccept = bm_en ? bm_acc      : man_acc;
  assign m_sresp      = bm_en ? noise_resp  : man_resp;
  assign m_sdata      = bm_en ? noise_sdata : man_sdata;

  // Host must see nothing of the bridge while a run is in progress
  int host_viol = 0;
  always @(negedge sccb_clk)
    if (busy && (h_scmdaccept || h_sresp != 2'b00 || h_sdata != 8'h00)) host_viol++;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] tbl[$]);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge sccb_clk); rom_we = 1'b1; rom_wa = 8'(i); rom_wd = tbl[i];
    end
    @(negedge sccb_clk); rom_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge sccb_clk); start = 1'b1;
    @(negedge sccb_clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin @(negedge sccb_clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles", tag, budget);
    end
  endtask

  // Reference: table walk from entry 0, stop at end marker or after 256
  // entries, delay entries produce no bus write.
  task automatic ref_model(input logic [15:0] tbl[$], output logic [14:0] ea[$],
                           output logic [7:0] ed[$]);
    logic [15:0] e;
    ea.delete(); ed.delete();
    for (int i = 0; i < 256 && i < tbl.size(); i++) begin
      e = tbl[i];
      if (e == 16'hFFFF) break;
      if (e[15:8] == 8'hFE) continue;
      ea.push_back({DEV, e[15:8]});
      ed.push_back(e[7:0]);
    end
  endtask

  task automatic cmp_writes(input string tag, input logic [15:0] tbl[$]);
    logic [14:0] ea[$];
    logic [7:0]  ed[$];
    ref_model(tbl, ea, ed);
    chk({tag, " nwrites"}, 64'(wa_log.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa_log.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 64'(wa_log[i]), 64'(ea[i]));
      chk($sformatf("%s data[%0d]", tag, i), 64'(wd_log[i]), 64'(ed[i]));
    end
  endtask

  typedef struct {
    logic [2:0] hc; logic [14:0] ha; logic [7:0] hd;
    logic ma; logic [1:0] mr; logic [7:0] ms;
    logic [2:0] e_mc; logic [14:0] e_ma; logic [7:0] e_md;
    logic e_ha; logic [1:0] e_hr; logic [7:0] e_hs;
  } pvec_t;

  initial begin
    pvec_t pv[4];
    logic [15:0] tbl[$];
    int n;

    pv[0] = '{3'b001, 15'h2112, 8'h80, 1'b1, 2'b00, 8'h00, 3'b001, 15'h2112, 8'h80, 1'b1, 2'b00, 8'h00};
    pv[1] = '{3'b010, 15'h7FFF, 8'h00, 1'b0, 2'b01, 8'hA5, 3'b010, 15'h7FFF, 8'h00, 1'b0, 2'b01, 8'hA5};
    pv[2] = '{3'b000, 15'h0000, 8'hFF, 1'b1, 2'b01, 8'h3C, 3'b000, 15'h0000, 8'hFF, 1'b1, 2'b01, 8'h3C};
    pv[3] = '{3'b001, 15'h5AA5, 8'h5A, 1'b0, 2'b10, 8'hFF, 3'b001, 15'h5AA5, 8'h5A, 1'b0, 2'b10, 8'hFF};

    // Reset state
    repeat (3) @(negedge sccb_clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    chk("reset m_mcmd", 64'(m_mcmd), 64'(3'b000));
    sccb_reset_n = 1'b1;
    @(negedge sccb_clk);

    // Passthrough vectors while idle
    for (int i = 0; i < 4; i++) begin
      h_mcmd = pv[i].hc; h_maddr = pv[i].ha; h_mdata = pv[i].hd;
      man_acc = pv[i].ma; man_resp = pv[i].mr; man_sdata = pv[i].ms;
      #1;
      chk($sformatf("idle passthru vec%0d", i),
          {m_mcmd, m_maddr, m_mdata, h_scmdaccept, h_sresp, h_sdata},
          {pv[i].e_mc, pv[i].e_ma, pv[i].e_md, pv[i].e_ha, pv[i].e_hr, pv[i].e_hs});
    end
    h_mcmd = 3'b000; h_maddr = 15'd0; h_mdata = 8'd0;
    man_acc = 1'b1; man_resp = 2'b00; man_sdata = 8'h00;
    bm_en = 1'b1;

    // Two writes then end marker
    tbl = '{16'h1280, 16'h1101, 16'hFFFF};
    load_rom(tbl);
    acc_lat = 2; cmpl_lat = 40;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    chk("basic busy after start", 64'(busy), 64'd1);
    wait_idle("basic", 1000, n);
    chk("basic done", 64'(done), 64'd1);
    chk("basic error", 64'(error), 64'd0);
    cmp_writes("basic", tbl);
    if (wa_log.size() == 2) begin
      chk("basic addr0 const", 64'(wa_log[0]), 64'h2112);
      chk("basic addr1 const", 64'(wa_log[1]), 64'h2111);
    end
    // Passthrough again in the finished state
    h_maddr = 15'h1234; h_mdata = 8'h77; #1;
    chk("done passthru addr", 64'(m_maddr), 64'h1234);
    chk("done passthru data", 64'(m_mdata), 64'h77);
    chk("done passthru acc", 64'(h_scmdaccept), 64'(m_scmdaccept));
    h_maddr = 15'd0; h_mdata = 8'd0;

    // Delay entry of 3 units (30 cycles) before the write
    tbl = '{16'hFE03, 16'h3A04, 16'hFFFF};
    load_rom(tbl);
    acc_lat = 1; cmpl_lat = 5;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    n = 0;
    while (!(busy && m_mcmd == CMD_WR) && n < 200) begin @(negedge sccb_clk); n++; end
    checks++;
    if (n < 30 || n > 40) begin
      errors++;
      $display("FAIL delay gap: got %0d cycles expected 30..40", n);
    end
    wait_idle("delay", 500, n);
    chk("delay done", 64'(done), 64'd1);
    cmp_writes("delay", tbl);

    // Bridge never accepts: timeout
    tbl = '{16'h1255, 16'hFFFF};
    load_rom(tbl);
    bm_stuck = 1'b1;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    wait_idle("timeout", 300, n);
    checks++;
    if (n < 95 || n > 120) begin
      errors++;
      $display("FAIL timeout latency: got %0d cycles expected 95..120", n);
    end
    chk("timeout error", 64'(error), 64'd1);
    chk("timeout done", 64'(done), 64'd0);
    chk("timeout m_mcmd", 64'(m_mcmd), 64'(3'b000));
    chk("timeout nwrites", 64'(wa_log.size()), 64'd0);
    bm_stuck = 1'b0;

    // Start while a host read holds the bridge busy
    tbl = '{16'h1477, 16'hFFFF};
    load_rom(tbl);
    acc_lat = 2; cmpl_lat = 10;
    bm_en = 1'b0; man_acc = 1'b0; h_mcmd = CMD_RD;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    repeat (4) @(negedge sccb_clk);
    chk("pending busy during read cmd", 64'(busy), 64'd0);
    h_mcmd = CMD_IDLE;
    repeat (3) @(negedge sccb_clk);
    chk("pending busy bridge busy", 64'(busy), 64'd0);
    man_acc = 1'b1; bm_en = 1'b1;
    @(negedge sccb_clk);
    chk("pending taken", 64'(busy), 64'd1);
    wait_idle("pending", 500, n);
    chk("pending done", 64'(done), 64'd1);
    cmp_writes("pending", tbl);

    // Reset while the sequencer waits for completion
    tbl = '{16'h1501, 16'h1602, 16'hFFFF};
    load_rom(tbl);
    acc_lat = 2; cmpl_lat = 40;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    n = 0;
    while (!bm_busy && n < 50) begin @(negedge sccb_clk); n++; end
    chk("rst midrun reached cmpl", 64'(bm_busy), 64'd1);
    repeat (2) @(negedge sccb_clk);
    h_maddr = 15'h0ABC;
    sccb_reset_n = 1'b0;
    #1;
    chk("rst midrun busy", 64'(busy), 64'd0);
    chk("rst midrun done", 64'(done), 64'd0);
    chk("rst midrun error", 64'(error), 64'd0);
    chk("rst midrun m_mcmd", 64'(m_mcmd), 64'(3'b000));
    chk("rst midrun passthru addr", 64'(m_maddr), 64'h0ABC);
    @(negedge sccb_clk); sccb_reset_n = 1'b1; h_maddr = 15'd0;
    repeat (60) @(negedge sccb_clk);
    chk("rst no resume busy", 64'(busy), 64'd0);
    chk("rst no resume nwrites", 64'(wa_log.size()), 64'd1);

    // Full 256-entry table without an end marker
    tbl.delete();
    for (int i = 0; i < 256; i++) tbl.push_back({8'(i % 200), 8'(i)});
    load_rom(tbl);
    acc_lat = 1; cmpl_lat = 2;
    wa_log.delete(); wd_log.delete();
    pulse_start();
    wait_idle("full", 5000, n);
    repeat (50) @(negedge sccb_clk);
    chk("full done", 64'(done), 64'd1);
    chk("full busy", 64'(busy), 64'd0);
    cmp_writes("full", tbl);

    // Randomized tables and bridge timing, with an ignored mid-run start
    for (int it = 0; it < 6; it++) begin
      int len;
      logic [15:0] e;
      len = $urandom_range(1, 24);
      tbl.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) e = {8'hFE, 8'($urandom_range(0, 3))};
        else begin
          e = 16'($urandom);
          if (e[15:8] == 8'hFE || e == 16'hFFFF) e[15:8] = 8'h42;
        end
        tbl.push_back(e);
      end
      tbl.push_back(16'hFFFF);
      load_rom(tbl);
      acc_lat = $urandom_range(1, 4); cmpl_lat = $urandom_range(1, 15);
      wa_log.delete(); wd_log.delete();
      pulse_start();
      @(negedge sccb_clk);
      if (busy) pulse_start();
      wait_idle($sformatf("rand%0d", it), 3000, n);
      repeat (20) @(negedge sccb_clk);
      chk($sformatf("rand%0d done", it), 64'(done), 64'd1);
      chk($sformatf("rand%0d error", it), 64'(error), 64'd0);
      cmp_writes($sformatf("rand%0d", it), tbl);
    end

    chk("host hidden during runs", 64'(host_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 SHALL have parameters: DEV_ID, default 7'h21, SCCB device ID driven on m_maddr[14:8]; DELAY_UNIT, default 16'd50000, sccb_clk cycles per delay tick; TIMEOUT, default 20'hFFFFF, max cycles spent waiting on the bridge.
REQ-002 SHALL have ports (name  direction  width  meaning):
- sccb_clk  in  1  clock
- sccb_reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: run init table
- busy  out  1  table run in progress
- done  out  1  last run reached end marker
- error  out  1  last run hit timeout
- h_mcmd  in  3  host command (000 idle, 001 write, 010 read)
- h_maddr  in  15  host address
- h_mdata  in  8  host write data
- h_scmdaccept  out  1  host command accepted
- h_sresp  out  2  host response (01 = DVA)
- h_sdata  out  8  host read data
- m_mcmd  out  3  bridge command
- m_maddr  out  15  bridge address
- m_mdata  out  8  bridge write data
- m_scmdaccept  in  1  bridge idle/accepting
- m_sresp  in  2  bridge response
- m_sdata  in  8  bridge read data
- rom_addr  out  8  table index to sccb_init_rom
- rom_data  in  16  table entry {reg[7:0], val[7:0]}

Function
REQ-003 SHALL implement states: IDLE, FETCH, DECODE, ISSUE, WAIT_ACC, WAIT_CMPL, DELAY, DONE.
REQ-004 In IDLE or DONE, host port SHALL pass through combinationally: m_* = h_*, h_scmdaccept = m_scmdaccept, h_sresp = m_sresp, h_sdata = m_sdata.
REQ-005 Outside IDLE/DONE: h_scmdaccept = 0, h_sresp = 00, h_sdata = 00, m_* driven by sequencer.
REQ-006 start in IDLE/DONE SHALL be taken only when m_scmdaccept = 1 and h_mcmd = 000; otherwise it SHALL be held pending (one-deep flag) until both hold; start while busy SHALL be ignored.
REQ-007 On taking start: index = 0, done = 0, error = 0, busy = 1, next state FETCH.
REQ-008 FETCH: drive rom_addr = index; DECODE one cycle later samples rom_data (1-cycle ROM latency).
REQ-009 DECODE: entry 16'hFFFF -> DONE; reg = 8'hFE -> DELAY with count = val x DELAY_UNIT (24-bit product); else -> ISSUE.
REQ-010 ISSUE/WAIT_ACC: m_mcmd = 001, m_maddr = {DEV_ID, reg}, m_mdata = val; held until m_scmdaccept samples 0, then m_mcmd = 000 and WAIT_CMPL.
REQ-011 WAIT_CMPL: wait for m_scmdaccept = 1; then index + 1 and FETCH.
REQ-012 Index 255 completed without end marker SHALL be treated as end: DONE, no wrap to 0.
REQ-013 DELAY: decrement counter each cycle, at 0 -> index + 1, FETCH; val = 0 delays 0 cycles (one pass through DELAY).
REQ-014 Timeout counter SHALL clear on every entry to WAIT_ACC/WAIT_CMPL and count there; reaching TIMEOUT -> m_mcmd = 000, error = 1, busy = 0, state IDLE.
REQ-015 DONE: busy = 0, done = 1 held until next accepted start.
REQ-016 Bridge response (m_sresp) during sequencer ownership SHALL be ignored.

Reset
REQ-017 Async reset SHALL force: state IDLE, busy 0, done 0, error 0, m_mcmd 000 (host passthrough active), index 0, counters 0, pending start 0.
REQ-018 Reset mid-run SHALL abandon the table; no resume.

Structure
REQ-019 Shared package SHALL hold command encodings (IDLE 000, WR 001, RD 010), response DVA 01, marker constants (END 16'hFFFF, DELAY 8'hFE) and state encodings.
REQ-020 Table SHALL live in sub-module sccb_init_rom (256x16, registered read), instantiated at the level above sccb_init_seq.

Verification
REQ-021 Table {12 80, 11 01, FFFF}, bridge model accepts in 2 cycles, completes in 40 -> two writes maddr 0x2112/0x2111, data 80/01, then done = 1, busy = 0.
REQ-022 Table {FE 03, 3A 04, FFFF}, DELAY_UNIT = 10 -> 30-cycle gap before write 0x213A/04.
REQ-023 Bridge holds m_scmdaccept = 1 forever, TIMEOUT = 100 -> error = 1 at ~100 cycles, m_mcmd = 000, state IDLE.
REQ-024 Start pulsed while host read in flight (m_scmdaccept = 0) -> sequencer waits, first write issued after bridge returns idle; host sees h_scmdaccept = 0 during run, h_sdata = 00.
REQ-025 Reset asserted during WAIT_CMPL -> busy/done/error 0, m_mcmd 000 immediately; host passthrough restored.
REQ-026 Table of 256 entries with no end marker -> 256 writes, then done = 1, no 257th write.
